// File: rtl/sa_left_feeder_if.sv
// Bundle of the upstream vector stream and the left-edge outputs of the systolic-array feeder.
// The master side drives start and the upstream stream. The slave side is the feeder itself.
interface sa_left_feeder_if #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 4
);
    logic                      start;
    logic                      s_valid;
    logic                      s_ready;
    logic [ROWS*BIT_WIDTH-1:0] s_data;
    logic                      s_last;
    logic                      load_weight;
    logic [ROWS*BIT_WIDTH-1:0] sa_left;
    logic [ROWS-1:0]           sa_left_vld;
    logic                      busy;
    logic                      done;

    modport master (
        output start, s_valid, s_data, s_last,
        input  s_ready, load_weight, sa_left, sa_left_vld, busy, done
    );

    modport slave (
        input  start, s_valid, s_data, s_last,
        output s_ready, load_weight, sa_left, sa_left_vld, busy, done
    );
endinterface

// File: rtl/sa_left_feeder.sv
// Left-edge driver of the weight-stationary systolic array.
// The feeder buffers one tile of COLS weight vectors and shifts them into the PE rows, last
// vector first. It then streams activation vectors into the rows with a diagonal skew, where
// row r is delayed by r cycles relative to row 0.
module sa_left_feeder #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 4,
    parameter int COLS      = 4
) (
    input logic           i_clk,
    input logic           i_reset,
    sa_left_feeder_if.slave bus
);
    localparam int MAXN = (COLS > ROWS) ? COLS : ROWS;
    localparam int CW   = $clog2(MAXN + 1);
    localparam int AW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW   = ROWS * BIT_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WFILL,
        WSHIFT,
        STREAM,
        FLUSH
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_nextCnt;
    logic            w_nextDone;
    logic            r_done;
    logic            r_loadWeight;
    logic [DW-1:0]   r_buf [0:COLS-1];

    logic            w_ready;
    logic            w_accept;
    logic            w_shift;
    logic [AW-1:0]   w_shiftIdx;
    logic [DW-1:0]   w_weight;
    logic [DW-1:0]   w_inject;
    logic            w_injectVld;
    logic [DW-1:0]   w_saLeft;
    logic [ROWS-1:0] w_saVld;

    assign w_ready     = (r_state == WFILL) || (r_state == STREAM);
    assign w_accept    = bus.s_valid && w_ready;
    assign w_shift     = (r_state == WSHIFT);
    assign w_shiftIdx  = AW'(COLS - 1) - r_cnt[AW-1:0];
    assign w_weight    = r_buf[w_shiftIdx];
    assign w_injectVld = (r_state == STREAM) && w_accept;
    assign w_inject    = w_injectVld ? bus.s_data : '0;

    // Next-state logic: weight fill, weight shift, activation stream, then drain the skew chains
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextDone  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nextState = WFILL;
                    w_nextCnt   = '0;
                end
            end
            WFILL: begin
                if (w_accept) begin
                    if (r_cnt == CW'(COLS - 1)) begin
                        w_nextState = WSHIFT;
                        w_nextCnt   = '0;
                    end else begin
                        w_nextCnt = r_cnt + 1'b1;
                    end
                end
            end
            WSHIFT: begin
                if (r_cnt == CW'(COLS - 1)) begin
                    w_nextState = STREAM;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            STREAM: begin
                if (w_accept && bus.s_last) begin
                    w_nextState = FLUSH;
                    w_nextCnt   = '0;
                end
            end
            FLUSH: begin
                if (r_cnt == CW'(ROWS - 1)) begin
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                    w_nextDone  = 1'b1;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
            end
        endcase
    end

    // State, counter and the registered load_weight/done outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_loadWeight <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_cnt        <= w_nextCnt;
            r_done       <= w_nextDone;
            r_loadWeight <= w_shift;
        end
    end

    // Weight tile buffer; its contents after a reset are irrelevant, so it has no reset
    always_ff @(posedge i_clk) begin
        if ((r_state == WFILL) && w_accept) begin
            r_buf[r_cnt[AW-1:0]] <= bus.s_data;
        end
    end

    // Per-row skew chains. Row r has r+1 stages and its last stage is the output register.
    // During a weight shift, the last stage is loaded directly so that all rows stay aligned.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [BIT_WIDTH-1:0] r_data [0:r];
        logic [r:0]           r_vld;

        // Shift this row's chain by one stage per cycle, or load a weight when shifting weights
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                for (int s = 0; s <= r; s++) begin
                    r_data[s] <= '0;
                end
                r_vld <= '0;
            end else begin
                r_data[0] <= w_inject[r*BIT_WIDTH +: BIT_WIDTH];
                r_vld[0]  <= w_injectVld;
                for (int s = 1; s <= r; s++) begin
                    r_data[s] <= r_data[s-1];
                    r_vld[s]  <= r_vld[s-1];
                end
                if (w_shift) begin
                    r_data[r] <= w_weight[r*BIT_WIDTH +: BIT_WIDTH];
                    r_vld[r]  <= 1'b0;
                end
            end
        end

        assign w_saLeft[r*BIT_WIDTH +: BIT_WIDTH] = r_data[r];
        assign w_saVld[r]                         = r_vld[r];
    end

    assign bus.s_ready     = w_ready;
    assign bus.load_weight = r_loadWeight;
    assign bus.sa_left     = w_saLeft;
    assign bus.sa_left_vld = w_saVld;
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
endmodule

// File: tb/tb_sa_left_feeder.sv
// Testbench for sa_left_feeder using a scoreboard.
// Stimulus tasks push the expected lane values, weight values and done cycles into queues.
// A negedge monitor pops entries from these queues and compares them with what the feeder presents.
module tb_sa_left_feeder;
    localparam int BW   = 4;
    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   cycleNum;
    int   compared;
    int   mismatched;
    int   lwCount;

    exp_t        laneQ [ROWS][$];
    int          doneQ [$];
    logic [15:0] weightQ [$];
    logic [3:0]  grid [ROWS][COLS];

    sa_left_feeder_if #(.BIT_WIDTH(BW), .ROWS(ROWS)) bus ();

    sa_left_feeder #(.BIT_WIDTH(BW), .ROWS(ROWS), .COLS(COLS)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    // Free-running clock and cycle counter; cycle k spans posedge k to posedge k+1
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycleNum = 0;
    always @(posedge clk) cycleNum++;

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycleNum, act, exp);
        end
    endtask

    // Drive one beat, hold it until s_ready, and return the cycle in which it was accepted
    task automatic applyStimulus(input logic [15:0] data, input logic last, input bit isStream,
                                 output int accCyc);
        int n;
        n = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = data;
        bus.s_last  = last;
        while (!bus.s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_wait", {31'd0, bus.s_ready}, 32'd1);
        accCyc = cycleNum;
        if (isStream && bus.s_ready) begin
            for (int r = 0; r < ROWS; r++) begin
                laneQ[r].push_back('{cyc: cycleNum + 1 + r, val: data[r*BW +: BW]});
            end
            if (last) doneQ.push_back(cycleNum + ROWS + 1);
        end
    endtask

    task automatic startTile();
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("start_busy", {31'd0, bus.busy}, 32'd1);
        checkOutput("start_ready", {31'd0, bus.s_ready}, 32'd1);
        lwCount = 0;
    endtask

    // Fill buf[c] with c in every lane; s_last is raised on one fill beat and must be ignored
    task automatic fillWeights(output int lastCyc);
        logic [3:0] cv;
        for (int c = 0; c < COLS; c++) begin
            cv = c[3:0];
            applyStimulus({cv, cv, cv, cv}, (c == 1), 1'b0, lastCyc);
        end
        weightQ.push_back(16'h3333);
        weightQ.push_back(16'h2222);
        weightQ.push_back(16'h1111);
        weightQ.push_back(16'h0000);
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
    endtask

    // Monitor: compare every visible output against the scoreboard queues
    always @(negedge clk) begin
        exp_t e;
        int   dc;
        logic [3:0] lane;
        logic [15:0] w;
        if (!rst) begin
            if (bus.load_weight) begin
                lwCount++;
                checkOutput("weight_expected", {31'd0, weightQ.size() != 0}, 32'd1);
                if (weightQ.size() != 0) begin
                    w = weightQ.pop_front();
                    checkOutput("weight_value", {16'd0, bus.sa_left}, {16'd0, w});
                end
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = COLS - 1; c > 0; c--) grid[r][c] = grid[r][c-1];
                    grid[r][0] = bus.sa_left[r*BW +: BW];
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                lane = bus.sa_left[r*BW +: BW];
                if (bus.sa_left_vld[r]) begin
                    checkOutput($sformatf("lane%0d_vld_expected", r),
                                {31'd0, laneQ[r].size() != 0}, 32'd1);
                    if (laneQ[r].size() != 0) begin
                        e = laneQ[r].pop_front();
                        checkOutput($sformatf("lane%0d_value", r), {28'd0, lane}, {28'd0, e.val});
                        checkOutput($sformatf("lane%0d_cycle", r), cycleNum, e.cyc);
                    end
                end else begin
                    if (!bus.load_weight)
                        checkOutput($sformatf("lane%0d_bubble_zero", r), {28'd0, lane}, 32'd0);
                    if (laneQ[r].size() != 0 && laneQ[r][0].cyc <= cycleNum) begin
                        e = laneQ[r].pop_front();
                        checkOutput($sformatf("lane%0d_missing_vld", r), cycleNum, e.cyc + 1000);
                    end
                end
            end
            if (bus.done) begin
                checkOutput("done_expected", {31'd0, doneQ.size() != 0}, 32'd1);
                checkOutput("done_busy_low", {31'd0, bus.busy}, 32'd0);
                if (doneQ.size() != 0) begin
                    dc = doneQ.pop_front();
                    checkOutput("done_cycle", cycleNum, dc);
                end
            end else if (doneQ.size() != 0 && doneQ[0] <= cycleNum) begin
                dc = doneQ.pop_front();
                checkOutput("done_missing", cycleNum, dc + 1000);
            end
        end
    end

    initial begin
        int acc;
        int fc;
        compared    = 0;
        mismatched  = 0;
        lwCount     = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) grid[r][c] = 4'hF;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_load_weight", {31'd0, bus.load_weight}, 32'd0);
        checkOutput("reset_sa_left", {16'd0, bus.sa_left}, 32'd0);
        checkOutput("reset_vld", {28'd0, bus.sa_left_vld}, 32'd0);
        checkOutput("reset_ready", {31'd0, bus.s_ready}, 32'd0);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // s_valid in IDLE is ignored
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h5A5A;
        checkOutput("idle_ready_low", {31'd0, bus.s_ready}, 32'd0);
        @(negedge clk);
        checkOutput("idle_busy_low", {31'd0, bus.busy}, 32'd0);
        bus.s_valid = 1'b0;

        // Weight load followed by a 3-vector skewed stream; start during STREAM is ignored
        startTile();
        fillWeights(fc);
        for (int i = 0; i < COLS; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = 16'hAAAA;
            checkOutput("wshift_ready_low", {31'd0, bus.s_ready}, 32'd0);
        end
        applyStimulus(16'h7654, 1'b0, 1'b1, acc);
        checkOutput("stream_first_accept", acc, fc + COLS + 1);
        bus.start = 1'b1;
        applyStimulus(16'hBA98, 1'b0, 1'b1, acc);
        bus.start = 1'b0;
        applyStimulus(16'hFEDC, 1'b1, 1'b1, acc);
        waitDone();
        checkOutput("lw_cycles", lwCount, COLS);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                checkOutput($sformatf("grid_r%0d_c%0d", r, c), {28'd0, grid[r][c]}, c);

        // Two bubble cycles between beats
        startTile();
        fillWeights(fc);
        applyStimulus(16'h7654, 1'b0, 1'b1, acc);
        repeat (2) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
        end
        applyStimulus(16'hBA98, 1'b1, 1'b1, acc);
        waitDone();
        checkOutput("lw_cycles_tile2", lwCount, COLS);

        // Reset in the middle of STREAM with vectors in flight
        startTile();
        fillWeights(fc);
        applyStimulus(16'h7654, 1'b0, 1'b1, acc);
        applyStimulus(16'hBA98, 1'b0, 1'b1, acc);
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.s_valid = 1'b0;
        for (int r = 0; r < ROWS; r++) laneQ[r].delete();
        doneQ.delete();
        weightQ.delete();
        #1;
        checkOutput("midreset_load_weight", {31'd0, bus.load_weight}, 32'd0);
        checkOutput("midreset_sa_left", {16'd0, bus.sa_left}, 32'd0);
        checkOutput("midreset_vld", {28'd0, bus.sa_left_vld}, 32'd0);
        checkOutput("midreset_ready", {31'd0, bus.s_ready}, 32'd0);
        checkOutput("midreset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midreset_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Restart after reset; s_last accepted on the first STREAM cycle
        startTile();
        fillWeights(fc);
        applyStimulus(16'h1357, 1'b1, 1'b1, acc);
        checkOutput("single_first_accept", acc, fc + COLS + 1);
        waitDone();
        checkOutput("lw_cycles_tile3", lwCount, COLS);

        // Everything that was expected must have been seen
        for (int r = 0; r < ROWS; r++)
            checkOutput($sformatf("lane%0d_queue_empty", r), laneQ[r].size(), 32'd0);
        checkOutput("done_queue_empty", doneQ.size(), 32'd0);
        checkOutput("weight_queue_empty", weightQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
